// File: rtl/warp_controller.sv
// Per-warp sequencer: owns the warp PC, fetches instructions and steps each one
// through decode, operand request, optional LSU wait, execute and write-back.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package warp_pkg;
  typedef enum logic [2:0] {
    WARP_IDLE,
    WARP_FETCH,
    WARP_DECODE,
    WARP_REQUEST,
    WARP_WAIT,
    WARP_EXECUTE,
    WARP_UPDATE,
    WARP_DONE
  } warp_state_t;
endpackage

module warp_controller
  import warp_pkg::*;
#(
  parameter int PC_WIDTH   = 8,
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  start,
  input  logic [PC_WIDTH-1:0]   start_pc,
  output logic                  fetch_req_valid,
  output logic [PC_WIDTH-1:0]   fetch_req_addr,
  input  logic                  fetch_resp_valid,
  input  logic [DATA_WIDTH-1:0] fetch_resp_instr,
  output logic [DATA_WIDTH-1:0] instruction,
  input  logic                  decoded_is_mem,
  input  logic                  decoded_is_halt,
  input  logic                  branch_taken,
  input  logic [PC_WIDTH-1:0]   branch_target,
  output logic                  lsu_req_valid,
  input  logic                  lsu_done,
  output warp_state_t           warp_state,
  output logic [PC_WIDTH-1:0]   pc,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] retired_count
);

  warp_state_t           state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] retired_q, retired_d;
  logic                  done_q, done_d;

  // With enable low nothing advances and no request is issued, so every
  // handshake input is ignored and the current state simply resumes later.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d         = state_q;
    pc_d            = pc_q;
    instr_d         = instr_q;
    retired_d       = retired_q;
    done_d          = done_q;
    fetch_req_valid = 1'b0;
    lsu_req_valid   = 1'b0;

    if (enable) begin
      unique case (state_q)
        WARP_IDLE, WARP_DONE: begin
          if (start) begin
            state_d   = WARP_FETCH;
            pc_d      = start_pc;
            retired_d = '0;
            done_d    = 1'b0;
          end
        end
        WARP_FETCH: begin
          fetch_req_valid = 1'b1;
          if (fetch_resp_valid) begin
            instr_d = fetch_resp_instr;
            state_d = WARP_DECODE;
          end
        end
        WARP_DECODE: state_d = WARP_REQUEST;
        WARP_REQUEST: begin
          // REQUEST is left on the same cycle, so the LSU launch is a single pulse.
          if (decoded_is_mem) begin
            lsu_req_valid = 1'b1;
            state_d       = WARP_WAIT;
          end else begin
            state_d = WARP_EXECUTE;
          end
        end
        WARP_WAIT: begin
          if (lsu_done) state_d = WARP_EXECUTE;
        end
        WARP_EXECUTE: state_d = WARP_UPDATE;
        WARP_UPDATE: begin
          retired_d = retired_q + 1'b1;
          if (decoded_is_halt) begin
            state_d = WARP_DONE;
            done_d  = 1'b1;
          end else if (branch_taken) begin
            pc_d    = branch_target;
            state_d = WARP_FETCH;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = WARP_FETCH;
          end
        end
        default: state_d = WARP_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and active-low; it is only seen on a clock edge.
    if (!reset) begin
      state_q   <= WARP_IDLE;
      pc_q      <= '0;
      instr_q   <= '0;
      retired_q <= '0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all update together.
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      done_q    <= done_d;
    end
  end

  assign warp_state     = state_q;
  assign pc             = pc_q;
  assign fetch_req_addr = pc_q;
  assign instruction    = instr_q;
  assign retired_count  = retired_q;
  assign done           = done_q;

endmodule

// File: tb/tb_warp_controller.sv
// Self-checking bench for warp_controller: acts as instruction memory, decoder,
// ALU and LSU, and predicts PC flow, latency and counters per instruction.

module tb_warp_controller;
  import warp_pkg::*;

  logic        clk = 1'b0;
  logic        reset, enable, start;
  logic [7:0]  start_pc;
  logic        fetch_req_valid;
  logic [7:0]  fetch_req_addr;
  logic        fetch_resp_valid;
  logic [31:0] fetch_resp_instr;
  logic [31:0] instruction;
  logic        decoded_is_mem, decoded_is_halt, branch_taken;
  logic [7:0]  branch_target;
  logic        lsu_req_valid, lsu_done;
  warp_state_t warp_state;
  logic [7:0]  pc;
  logic        done;
  logic [31:0] retired_count;

  int checks = 0;
  int errors = 0;

  // Reference model of the architectural state
  logic [7:0]  m_pc;
  logic [31:0] m_retired;

  always #5 clk = ~clk;

  warp_controller #(.PC_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .start            (start),
    .start_pc         (start_pc),
    .fetch_req_valid  (fetch_req_valid),
    .fetch_req_addr   (fetch_req_addr),
    .fetch_resp_valid (fetch_resp_valid),
    .fetch_resp_instr (fetch_resp_instr),
    .instruction      (instruction),
    .decoded_is_mem   (decoded_is_mem),
    .decoded_is_halt  (decoded_is_halt),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .lsu_req_valid    (lsu_req_valid),
    .lsu_done         (lsu_done),
    .warp_state       (warp_state),
    .pc               (pc),
    .done             (done),
    .retired_count    (retired_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge from IDLE or DONE; returns in the first FETCH cycle.
  task automatic launch(input logic [7:0] addr);
    start    = 1'b1;
    start_pc = addr;
    @(negedge clk);
    start    = 1'b0;
    start_pc = 8'($urandom);
    m_pc      = addr;
    m_retired = '0;
    #1;
    check("launch_state", warp_state, WARP_FETCH);
    check("launch_pc", pc, addr);
    check("launch_retired", retired_count, 32'd0);
    check("launch_done", done, 1'b0);
    check("launch_fetch_valid", fetch_req_valid, 1'b1);
  endtask

  // Runs one instruction starting in its first FETCH cycle and returns at the
  // negedge after its UPDATE cycle. freeze = disabled cycles before the fetch,
  // stalls = enabled fetch cycles without a response, nwait = WAIT cycles before
  // lsu_done, noisy = random enable drops, stray handshakes and ignored starts.
  task automatic run_instr(input int stalls, input int freeze, input bit mem, input int nwait,
                           input bit halt, input bit br, input logic [7:0] tgt, input bit noisy);
    logic [31:0] word;
    int cyc, off, since_req, lsu_pulses, exp_cyc;
    bit accepted, req_seen, finished, en, in_fetch;
    word = $urandom;
    cyc = 0; off = 0; since_req = 0; lsu_pulses = 0;
    accepted = 1'b0; req_seen = 1'b0; finished = 1'b0;
    decoded_is_mem  = mem;
    decoded_is_halt = halt;
    branch_taken    = br;
    branch_target   = tgt;
    for (int i = 0; i < 200 && !finished; i++) begin
      in_fetch = !accepted;
      if (in_fetch) begin
        en               = (cyc >= freeze);
        fetch_resp_valid = !en || (cyc >= freeze + stalls);
        fetch_resp_instr = en ? word : ~word;
        lsu_done         = 1'b1;
      end else begin
        en               = !(noisy && $urandom_range(0, 5) == 0);
        fetch_resp_valid = noisy && 1'($urandom_range(0, 1));
        fetch_resp_instr = $urandom;
        if (req_seen && en) since_req++;
        lsu_done = req_seen && (en ? (since_req == nwait + 1) : noisy);
        if (!en) off++;
      end
      start    = noisy && $urandom_range(0, 3) == 0;
      start_pc = 8'($urandom);
      enable   = en;
      #1;
      if (in_fetch) begin
        check(en ? "fetch_valid" : "freeze_fetch_valid", fetch_req_valid, en);
        check("fetch_addr", fetch_req_addr, m_pc);
        check("fetch_state", warp_state, WARP_FETCH);
        if (en && fetch_resp_valid && fetch_req_valid) accepted = 1'b1;
      end
      if (lsu_req_valid) begin
        lsu_pulses++;
        req_seen = 1'b1;
      end
      if (en && warp_state == WARP_UPDATE) begin
        check("update_instr", instruction, word);
        check("update_retired", retired_count, m_retired);
        finished = 1'b1;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0; enable = 1'b1; fetch_resp_valid = 1'b0; lsu_done = 1'b0;
    check("instr_finished", finished, 1'b1);
    exp_cyc = 5 + stalls + freeze + off + (mem ? 1 + nwait : 0);
    check("instr_latency", cyc, exp_cyc);
    check("lsu_pulses", lsu_pulses, {31'd0, mem});
    m_retired = m_retired + 1;
    if (!halt) m_pc = br ? tgt : m_pc + 8'd1;
  endtask

  task automatic check_halted(input int hold);
    for (int i = 0; i < hold; i++) begin
      lsu_done = 1'b1;
      #1;
      check("done_flag", done, 1'b1);
      check("done_state", warp_state, WARP_DONE);
      check("done_pc", pc, m_pc);
      check("done_retired", retired_count, m_retired);
      check("done_fetch_valid", fetch_req_valid, 1'b0);
      @(negedge clk);
    end
    lsu_done = 1'b0;
  endtask

  initial begin
    bit seen;
    reset = 1'b0; enable = 1'b1; start = 1'b0; start_pc = '0;
    fetch_resp_valid = 1'b0; fetch_resp_instr = '0;
    decoded_is_mem = 1'b0; decoded_is_halt = 1'b0; branch_taken = 1'b0;
    branch_target = '0; lsu_done = 1'b0;
    m_pc = '0; m_retired = '0;

    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_state", warp_state, WARP_IDLE);
    check("rst_pc", pc, 8'h00);
    check("rst_instr", instruction, 32'd0);
    check("rst_retired", retired_count, 32'd0);
    check("rst_done", done, 1'b0);
    check("rst_fetch_valid", fetch_req_valid, 1'b0);
    check("rst_lsu_valid", lsu_req_valid, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Straight-line code: three ALU instructions, then halt
    launch(8'h10);
    for (int k = 0; k < 3; k++) run_instr(0, 0, 1'b0, 0, 1'b0, 1'b0, 8'h00, 1'b0);
    run_instr(0, 0, 1'b0, 0, 1'b1, 1'b0, 8'h00, 1'b0);
    check("straight_pc", pc, 8'h13);
    check("straight_retired", retired_count, 32'd4);
    check_halted(3);

    // Relaunch from DONE, branch, PC wrap, halt taking precedence over branch
    launch(8'h20);
    run_instr(0, 0, 1'b0, 0, 1'b0, 1'b1, 8'h05, 1'b0);
    run_instr(0, 0, 1'b0, 0, 1'b0, 1'b1, 8'hFF, 1'b0);
    run_instr(0, 0, 1'b0, 0, 1'b0, 1'b0, 8'h00, 1'b0);
    check("wrap_pc", pc, 8'h00);
    run_instr(0, 0, 1'b0, 0, 1'b1, 1'b1, 8'h77, 1'b0);
    check_halted(2);

    // Load with 3 WAIT cycles and 2 fetch stalls, then a 4-cycle fetch freeze
    launch(8'h30);
    run_instr(2, 0, 1'b1, 3, 1'b0, 1'b0, 8'h00, 1'b0);
    run_instr(0, 4, 1'b0, 0, 1'b0, 1'b0, 8'h00, 1'b0);
    run_instr(0, 0, 1'b0, 0, 1'b1, 1'b0, 8'h00, 1'b0);
    check_halted(1);

    // Random program
    launch(8'($urandom));
    for (int k = 0; k < 30; k++) begin
      run_instr($urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                $urandom_range(0, 4), 1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
    end
    run_instr(1, 1, 1'b1, 2, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
    check_halted(2);

    // Reset held for two cycles in the middle of a WAIT
    launch(8'h40);
    run_instr(0, 0, 1'b0, 0, 1'b0, 1'b0, 8'h00, 1'b0);
    decoded_is_mem   = 1'b1;
    decoded_is_halt  = 1'b0;
    fetch_resp_valid = 1'b1;
    fetch_resp_instr = $urandom;
    lsu_done         = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      #1;
      seen = lsu_req_valid;
      @(negedge clk);
    end
    check("rstw_lsu_req_seen", seen, 1'b1);
    @(negedge clk);
    #1;
    check("rstw_in_wait", warp_state, WARP_WAIT);
    check("rstw_pc_before", pc, 8'h41);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("rstw_state_first_edge", warp_state, WARP_IDLE);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rstw_state", warp_state, WARP_IDLE);
    check("rstw_pc", pc, 8'h00);
    check("rstw_retired", retired_count, 32'd0);
    check("rstw_instr", instruction, 32'd0);
    check("rstw_done", done, 1'b0);
    check("rstw_fetch_valid", fetch_req_valid, 1'b0);
    check("rstw_lsu_valid", lsu_req_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
